// File: rtl/rr_merge2.sv
// rr_merge2 -- two-input round-robin stream merger with a one-entry output
// register.
//
// Two valid/ready producers (A and B) compete for a single output register.
// select_o carries the current grant using the mux2 select encoding
// (0 = A, 1 = B), so the downstream mux2 can be driven directly from it.
// When both producers are valid, the one not served last wins. The output
// register drains and refills in the same cycle, so a new word can be taken
// every cycle.
//
// Ports:
//   clk_i      clock; all state updates on the rising edge
//   reset_ni   asynchronous active-low reset
//   a_valid_i  producer A has a word
//   a_data_i   producer A data
//   a_ready_o  A word accepted this cycle when a_valid_i & a_ready_o
//   b_valid_i  producer B has a word
//   b_data_i   producer B data
//   b_ready_o  B word accepted this cycle when b_valid_i & b_ready_o
//   select_o   current grant (0 = A, 1 = B), combinational
//   valid_o    output register holds a word
//   data_o     output register contents
//   ready_i    consumer accepts data_o when valid_o & ready_i

module rr_merge2 #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               a_valid_i,
  input  logic [width_p-1:0] a_data_i,
  output logic               a_ready_o,
  input  logic               b_valid_i,
  input  logic [width_p-1:0] b_data_i,
  output logic               b_ready_o,
  output logic               select_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

  // Input served by the most recent handshake (0 = A, 1 = B).
  logic last_q;
  logic free;
  logic take;

  // The register can take a word when it is empty or being drained this cycle.
  assign free = ~valid_o | ready_i;

  // A lone requester always wins. With both or neither valid, the grant points
  // at the input that was not served last, so an idle period leaves the
  // pointer where it was.
  always_comb begin
    select_o = ~last_q;
    if (a_valid_i && !b_valid_i) begin
      select_o = 1'b0;
    end else if (b_valid_i && !a_valid_i) begin
      select_o = 1'b1;
    end
  end

  assign a_ready_o = free & ~select_o;
  assign b_ready_o = free &  select_o;

  // Only the granted input can see ready, so at most one handshake per cycle.
  assign take = (a_valid_i & a_ready_o) | (b_valid_i & b_ready_o);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_q  <= 1'b1;    // B counts as last served, so A wins the first contest
    end else if (take) begin
      // A fill covers both the empty case and a simultaneous drain and refill.
      data_o  <= select_o ? b_data_i : a_data_i;
      valid_o <= 1'b1;
      last_q  <= select_o;
    end else if (ready_i) begin
      // Drain with nothing to refill; data_o keeps its last value.
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_merge2.sv
// tb_rr_merge2 -- self-checking bench for rr_merge2.
//
// A reference model keeps a history of which producer was served and the
// contents of the output slot; grants follow the round-robin rule taken
// directly from that history. Directed scenarios are followed by a
// randomized run with producers that hold their word until it is accepted.

module tb_rr_merge2;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         reset_ni;
  logic         a_valid_i;
  logic [W-1:0] a_data_i;
  logic         a_ready_o;
  logic         b_valid_i;
  logic [W-1:0] b_data_i;
  logic         b_ready_o;
  logic         select_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         ready_i;

  rr_merge2 #(.width_p(W)) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .a_valid_i (a_valid_i),
    .a_data_i  (a_data_i),
    .a_ready_o (a_ready_o),
    .b_valid_i (b_valid_i),
    .b_data_i  (b_data_i),
    .b_ready_o (b_ready_o),
    .select_o  (select_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .ready_i   (ready_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model state: history of served producers (0 = A, 1 = B) and
  // the output slot.
  int           served_q[$];
  logic         m_valid;
  logic [W-1:0] m_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    served_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  // One clock cycle: drive inputs, check grant and readies, advance the clock,
  // update the model and check the output register.
  // Called at (posedge + 1) and returns at (next posedge + 1).
  task automatic cycle(input logic av, input logic [W-1:0] ad,
                       input logic bv, input logic [W-1:0] bd,
                       input logic rdy,
                       output logic a_acc, output logic b_acc);
    int   last_id;
    logic esel;
    logic free;
    a_valid_i = av;
    a_data_i  = ad;
    b_valid_i = bv;
    b_data_i  = bd;
    ready_i   = rdy;
    last_id = (served_q.size() != 0) ? served_q[$] : 1;
    if (av && !bv)      esel = 1'b0;
    else if (bv && !av) esel = 1'b1;
    else                esel = (last_id == 0);
    free = !m_valid || rdy;
    #2;
    check_eq("select_o", select_o, esel);
    check_eq("a_ready_o", a_ready_o, free && !esel);
    check_eq("b_ready_o", b_ready_o, free && esel);
    // mux2 fed by select_o must pass the granted producer's data.
    check_eq("mux2_out", select_o ? b_data_i : a_data_i, esel ? bd : ad);
    a_acc = av && free && !esel;
    b_acc = bv && free && esel;
    @(posedge clk_i);
    #1;
    if (a_acc) begin
      served_q.push_back(0);
      m_valid = 1'b1;
      m_data  = ad;
      $display("xfer A data=%h t=%0t", ad, $time);
    end else if (b_acc) begin
      served_q.push_back(1);
      m_valid = 1'b1;
      m_data  = bd;
      $display("xfer B data=%h t=%0t", bd, $time);
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (served_q.size() > 4) void'(served_q.pop_front());
    check_eq("valid_o", valid_o, m_valid);
    check_eq("data_o", data_o, m_data);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic         aa, ba;
    logic         apend, bpend;
    logic [W-1:0] adat, bdat;
    logic [W-1:0] ia, ib;
    logic [W-1:0] word;

    // ---------------- reset with both producers valid ----------------
    reset_ni  = 1'b0;
    a_valid_i = 1'b1;
    a_data_i  = 8'h11;
    b_valid_i = 1'b1;
    b_data_i  = 8'h22;
    ready_i   = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_valid", valid_o, 1'b0);
    check_eq("rst_data", data_o, 8'h00);
    reset_ni = 1'b1;
    #2;
    check_eq("rst_select", select_o, 1'b0);
    check_eq("rst_a_ready", a_ready_o, 1'b1);
    check_eq("rst_b_ready", b_ready_o, 1'b0);
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    @(posedge clk_i);
    #1;

    // ---------------- contention: A0,B0,A1,B1,... ----------------
    ia = 8'hA0;
    ib = 8'hB0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, ia, 1'b1, ib, 1'b1, aa, ba);
      word = (k % 2 == 0) ? (8'hA0 + 8'(k / 2)) : (8'hB0 + 8'(k / 2));
      check_eq("ctn_data", data_o, word);
      if (aa) ia = ia + 8'd1;
      if (ba) ib = ib + 8'd1;
    end

    // ---------------- single source A ----------------
    foreach (ia[i]) begin end
    for (int k = 1; k <= 3; k++) begin
      word = 8'(k * 8'h11);
      cycle(1'b1, word, 1'b0, 8'h00, 1'b1, aa, ba);
      check_eq("single_data", data_o, word);
      check_eq("single_valid", valid_o, 1'b1);
    end
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);
    check_eq("single_drain", valid_o, 1'b0);

    // ---------------- backpressure ----------------
    cycle(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, aa, ba);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'h6B, 1'b0, 8'h00, 1'b0, aa, ba);
      check_eq("bp_data", data_o, 8'h5A);
      check_eq("bp_valid", valid_o, 1'b1);
      check_eq("bp_no_accept", aa, 1'b0);
    end
    cycle(1'b1, 8'h6B, 1'b0, 8'h00, 1'b1, aa, ba);
    check_eq("bp_release", data_o, 8'h6B);
    check_eq("bp_release_valid", valid_o, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);

    // ---------------- pointer hold across idle ----------------
    cycle(1'b0, 8'h00, 1'b1, 8'hC1, 1'b1, aa, ba);
    check_eq("ptr_b_word", data_o, 8'hC1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);
      check_eq("ptr_idle_sel", select_o, 1'b0);
    end
    cycle(1'b1, 8'hD1, 1'b1, 8'hD2, 1'b1, aa, ba);
    check_eq("ptr_a_wins", data_o, 8'hD1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, aa, ba);

    // ---------------- asynchronous reset mid-stream ----------------
    cycle(1'b1, 8'hE0, 1'b1, 8'hE1, 1'b1, aa, ba);
    cycle(1'b1, 8'hE2, 1'b1, 8'hE1, 1'b1, aa, ba);
    #1;
    reset_ni = 1'b0;
    #1;
    check_eq("async_valid", valid_o, 1'b0);
    check_eq("async_data", data_o, 8'h00);
    model_reset();
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    cycle(1'b1, 8'hF0, 1'b1, 8'hF1, 1'b1, aa, ba);
    check_eq("async_first_grant", data_o, 8'hF0);
    cycle(1'b1, 8'hF2, 1'b1, 8'hF1, 1'b1, aa, ba);
    check_eq("async_second_grant", data_o, 8'hF1);

    // ---------------- randomized traffic ----------------
    apend = 1'b0;
    bpend = 1'b0;
    adat  = '0;
    bdat  = '0;
    for (int n = 0; n < 400; n++) begin
      if (!apend && $urandom_range(0, 2) != 0) begin
        apend = 1'b1;
        adat  = W'($urandom);
      end
      if (!bpend && $urandom_range(0, 2) != 0) begin
        bpend = 1'b1;
        bdat  = W'($urandom);
      end
      cycle(apend, adat, bpend, bdat, ($urandom_range(0, 3) != 0), aa, ba);
      if (aa) apend = 1'b0;
      if (ba) bpend = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_merge2.md
Name: rr_merge2

Overview:
- Two-input round-robin stream merger that sits directly upstream of the team's mux2.
- It arbitrates between two valid/ready producers (A, B) and drives select_o, using the mux2 convention: 0 picks a_i, 1 picks b_i.
- The winning word is captured in a one-entry output register with a valid/ready handshake, so merged traffic reaches the next stage with one cycle of latency.
- The block sustains full throughput of one word per cycle.

Parameters:
- width_p, 8, data width of each input and of data_o

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- reset_ni  input  1  asynchronous active-low reset
- a_valid_i  input  1  producer A has a word
- a_data_i  input  width_p  producer A data
- a_ready_o  output  1  A word accepted this cycle when a_valid_i & a_ready_o
- b_valid_i  input  1  producer B has a word
- b_data_i  input  width_p  producer B data
- b_ready_o  output  1  B word accepted this cycle when b_valid_i & b_ready_o
- select_o  output  1  current grant (0=A, 1=B); combinational; same encoding as mux2 select_i
- valid_o  output  1  output register holds a word
- data_o  output  width_p  output register contents
- ready_i  input  1  consumer accepts data_o when valid_o & ready_i

Behaviour:
- Reset:
  - Clock is clk_i. Reset is asynchronous and active-low on reset_ni.
  - While reset_ni=0: valid_o=0, data_o=0, last_q=1 (B treated as last served, so A wins the first contest).
- Output register:
  - free = ~valid_o | ready_i.
  - The register accepts a new word only when free=1.
- Grant (combinational):
  - A only valid: select_o=0.
  - B only valid: select_o=1.
  - Both valid: select_o = ~last_q (the input not served last).
  - Neither valid: select_o = ~last_q.
- Readies:
  - a_ready_o = free & (select_o==0).
  - b_ready_o = free & (select_o==1).
  - At most one ready is high per cycle. Readies never depend on ready_i except through free.
- Transfer:
  - On a handshake on the granted input: data_o <= granted data, valid_o <= 1, last_q <= select_o.
  - The loser's data and valid are untouched and it retries next cycle.
- Drain:
  - If valid_o & ready_i and no input handshake: valid_o <= 0, data_o holds its value.
- Stall:
  - If valid_o & ~ready_i: data_o, valid_o and last_q all hold.
  - Both readies are 0.
- Latency: an input word appears on data_o the cycle after its handshake.
- Throughput: back-to-back handshakes are allowed every cycle while ready_i=1.
- Simultaneous drain and fill (valid_o & ready_i & input handshake): the new word replaces the old one and valid_o stays 1.
- last_q updates only on an input handshake. Idle cycles never move the pointer.
- Fairness: with both inputs continuously valid and ready_i=1, grants alternate A,B,A,B…
- Reset mid-operation:
  - Any word in flight is discarded; valid_o drops to 0 immediately (asynchronously).
  - On release, the first contest goes to A.
- No X propagation: data_o changes only on a handshake or reset.

Test Plan:
- Reset: hold reset_ni=0 for 2 cycles, both valids=1 → valid_o=0, data_o=0, select_o=0, a_ready_o=1, b_ready_o=0 after release.
- Single source: A sends 8'h11, 8'h22, 8'h33 on consecutive cycles, B idle, ready_i=1 → data_o=11,22,33 one cycle after each; valid_o=1 three cycles then 0.
- Contention:
  - Stimulus: both valid continuously, A streams 8'hA0.., B streams 8'hB0.., ready_i=1.
  - Required: data_o = A0,B0,A1,B1,…; select_o toggles every cycle.
- Backpressure:
  - Stimulus: word 8'h5A registered, then ready_i=0 for 3 cycles.
  - Required: data_o=5A and valid_o=1 held; a_ready_o=b_ready_o=0.
  - Required on ready_i=1 with A valid 8'h6B: 6B appears next cycle with no bubble.
- Pointer hold:
  - Stimulus: B sends one word, 4 idle cycles, then both valid.
  - Required: A wins (last_q=1 retained); select_o=0 during idle.
- Async reset mid-stream: drop reset_ni between clock edges during contention → valid_o=0 immediately without a clock edge; after release A wins first grant.
- Mux compatibility: for all 4 combinations of (a_valid_i, b_valid_i), compare select_o against the expected grant and feed select_o, a_data_i, b_data_i into mux2 → mux2 output equals the granted data each cycle.
